// File: rtl/openfire_store_unit_pkg.sv
// ============================================================================
// Module      : openfire_store_unit_pkg
// Description : Size encodings, byte-enable constants and drain-FSM states
//               shared by the OpenFire store path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package openfire_store_unit_pkg;

    localparam logic [1:0] ST_BYTE    = 2'b00;
    localparam logic [1:0] ST_HALF    = 2'b01;
    localparam logic [1:0] ST_WORD    = 2'b10;
    localparam logic [1:0] ST_ILLEGAL = 2'b11;

    // be[3] selects bits [31:24], the lowest byte address in big-endian order
    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B0   = 4'b1000;
    localparam logic [3:0] BE_B1   = 4'b0100;
    localparam logic [3:0] BE_B2   = 4'b0010;
    localparam logic [3:0] BE_B3   = 4'b0001;
    localparam logic [3:0] BE_H0   = 4'b1100;
    localparam logic [3:0] BE_H1   = 4'b0011;
    localparam logic [3:0] BE_W    = 4'b1111;

    typedef enum logic [0:0] {
        DRAIN_IDLE  = 1'b0,
        DRAIN_WRITE = 1'b1
    } drain_state_t;

    function automatic logic [3:0] byte_be(input logic [1:0] lsb);
        case (lsb)
            2'b00:   byte_be = BE_B0;
            2'b01:   byte_be = BE_B1;
            2'b10:   byte_be = BE_B2;
            default: byte_be = BE_B3;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/openfire_store_unit_if.sv
// ============================================================================
// Module      : openfire_store_unit_if
// Description : Data-memory write bus (req/ack handshake) of the store unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface openfire_store_unit_if #(
    parameter int ADDR_W = 18
);
    logic              dmem_wr_req;
    logic              dmem_wr_ack;
    logic [ADDR_W-1:0] dmem_wr_addr;
    logic [31:0]       dmem_wr_data;
    logic [3:0]        dmem_wr_be;

    modport master (
        output dmem_wr_req,
        output dmem_wr_addr,
        output dmem_wr_data,
        output dmem_wr_be,
        input  dmem_wr_ack
    );

    modport slave (
        input  dmem_wr_req,
        input  dmem_wr_addr,
        input  dmem_wr_data,
        input  dmem_wr_be,
        output dmem_wr_ack
    );
endinterface

`default_nettype wire

// File: rtl/openfire_store_unit_fifo.sv
// ============================================================================
// Module      : openfire_store_fifo
// Description : SB_DEPTH-entry store buffer holding {word addr, data, be};
//               exposes the head and the entry behind it for back-to-back drain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module openfire_store_fifo #(
    parameter int ADDR_W   = 18,
    parameter int SB_DEPTH = 2,
    parameter int PTR_W    = $clog2(SB_DEPTH),
    parameter int CNT_W    = $clog2(SB_DEPTH) + 1
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              push_i,
    input  wire logic              pop_i,
    input  wire logic [ADDR_W-3:0] wr_addr_i,
    input  wire logic [31:0]       wr_data_i,
    input  wire logic [3:0]        wr_be_i,
    output logic      [ADDR_W-3:0] head_addr_o,
    output logic      [31:0]       head_data_o,
    output logic      [3:0]        head_be_o,
    output logic      [ADDR_W-3:0] next_addr_o,
    output logic      [31:0]       next_data_o,
    output logic      [3:0]        next_be_o,
    output logic      [CNT_W-1:0]  count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    logic [ADDR_W-3:0] addr_q [SB_DEPTH];
    logic [31:0]       data_q [SB_DEPTH];
    logic [3:0]        be_q   [SB_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  nx_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == CNT_W'(SB_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign nx_ptr  = rd_ptr_q + PTR_W'(1);

    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign head_be_o   = be_q[rd_ptr_q];
    assign next_addr_o = addr_q[nx_ptr];
    assign next_data_o = data_q[nx_ptr];
    assign next_be_o   = be_q[nx_ptr];

    // Power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            if (do_push) begin
                addr_q[wr_ptr_q] <= wr_addr_i;
                data_q[wr_ptr_q] <= wr_data_i;
                be_q[wr_ptr_q]   <= wr_be_i;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= nx_ptr;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/openfire_store_unit.sv
// ============================================================================
// Module      : openfire_store_unit
// Description : Big-endian store lane formatter, store buffer and DMEM drain
//               FSM. Optional macro OPENFIRE_STORE_ALIGN_CHECK_EN adds align_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module openfire_store_unit
    import openfire_store_unit_pkg::*;
#(
    parameter int ADDR_W   = 18,
    parameter int SB_DEPTH = 2
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              enable,
    input  wire logic              st_valid,
    input  wire logic [1:0]        st_size,
    input  wire logic [ADDR_W-1:0] st_addr,
    input  wire logic [31:0]       st_data,
    output logic                   st_stall,
    output logic                   sb_empty,
`ifdef OPENFIRE_STORE_ALIGN_CHECK_EN
    output logic                   align_err,
`endif
    openfire_store_unit_if.master  dmem
);

    localparam int CNT_W = $clog2(SB_DEPTH) + 1;

    logic [31:0]       fmt_data;
    logic [3:0]        fmt_be;
    logic              fmt_ok;
    logic              offer;
    logic              push;
    logic              pop;

    logic [ADDR_W-3:0] head_addr, next_addr;
    logic [31:0]       head_data, next_data;
    logic [3:0]        head_be, next_be;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full, fifo_empty;

    drain_state_t      state_q, state_d;
    logic [ADDR_W-3:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [3:0]        be_q, be_d;

    always_comb begin
        fmt_data = st_data;
        fmt_be   = BE_NONE;
        case (st_size)
            ST_BYTE: begin
                fmt_data = {4{st_data[7:0]}};
                fmt_be   = byte_be(st_addr[1:0]);
            end
            ST_HALF: begin
                fmt_data = {2{st_data[15:0]}};
                fmt_be   = (st_addr[1:0] == 2'b00) ? BE_H0 : BE_H1;
            end
            ST_WORD: fmt_be = BE_W;
            default: fmt_be = BE_NONE;
        endcase
    end

    assign offer = st_valid & enable;

`ifdef OPENFIRE_STORE_ALIGN_CHECK_EN
    logic bad;
    logic align_err_q;

    assign bad = (st_size == ST_ILLEGAL) |
                 (((st_size == ST_HALF) | (st_size == ST_WORD)) & (st_addr[1:0] != 2'b00));
    assign fmt_ok   = ~bad;
    // A rejected store is dropped, so it must never hold the pipeline
    assign st_stall = offer & fifo_full & ~bad;
    assign align_err = align_err_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= offer & bad;
        end
    end
`else
    assign fmt_ok   = (st_size != ST_ILLEGAL);
    assign st_stall = offer & fifo_full;
`endif

    assign push = offer & fmt_ok & ~fifo_full;

    openfire_store_fifo #(
        .ADDR_W   (ADDR_W),
        .SB_DEPTH (SB_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (push),
        .pop_i       (pop),
        .wr_addr_i   (st_addr[ADDR_W-1:2]),
        .wr_data_i   (fmt_data),
        .wr_be_i     (fmt_be),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .head_be_o   (head_be),
        .next_addr_o (next_addr),
        .next_data_o (next_data),
        .next_be_o   (next_be),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // The in-flight write stays in the buffer until acked, so count covers it
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        pop     = 1'b0;
        case (state_q)
            DRAIN_IDLE: begin
                if (!fifo_empty) begin
                    state_d = DRAIN_WRITE;
                    addr_d  = head_addr;
                    data_d  = head_data;
                    be_d    = head_be;
                end
            end
            DRAIN_WRITE: begin
                if (dmem.dmem_wr_ack) begin
                    pop = 1'b1;
                    if (fifo_count > CNT_W'(1)) begin
                        addr_d = next_addr;
                        data_d = next_data;
                        be_d   = next_be;
                    end else begin
                        state_d = DRAIN_IDLE;
                    end
                end
            end
            default: state_d = DRAIN_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= DRAIN_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
        end
    end

    assign dmem.dmem_wr_req  = (state_q == DRAIN_WRITE);
    assign dmem.dmem_wr_addr = {addr_q, 2'b00};
    assign dmem.dmem_wr_data = data_q;
    assign dmem.dmem_wr_be   = be_q;
    assign sb_empty          = (fifo_count == '0) & ~dmem.dmem_wr_req;

endmodule

`default_nettype wire

// File: tb/tb_openfire_store_unit.sv
// ============================================================================
// Module      : tb_openfire_store_unit
// Description : Directed, table-driven bench for openfire_store_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_openfire_store_unit;

    localparam int ADDR_W = 18;

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic              st_valid;
    logic [1:0]        st_size;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic              st_stall;
    logic              sb_empty;
`ifdef OPENFIRE_STORE_ALIGN_CHECK_EN
    logic              align_err;
`endif

    int checks   = 0;
    int failures = 0;

    openfire_store_unit_if #(.ADDR_W(ADDR_W)) dmem_if ();

    openfire_store_unit #(
        .ADDR_W   (ADDR_W),
        .SB_DEPTH (2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .st_valid (st_valid),
        .st_size  (st_size),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_stall (st_stall),
        .sb_empty (sb_empty),
`ifdef OPENFIRE_STORE_ALIGN_CHECK_EN
        .align_err(align_err),
`endif
        .dmem     (dmem_if.master)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [ADDR_W-1:0] exp_addr;
        logic [31:0]       exp_data;
        logic [3:0]        exp_be;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [1:0] sz, input logic [ADDR_W-1:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_size  = sz;
        st_addr  = a;
        st_data  = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{2'b00, 18'h0102, 32'h0000_00A5, 18'h0100, 32'hA5A5_A5A5, 4'b0010};
        vecs[1] = '{2'b00, 18'h0100, 32'h1234_563C, 18'h0100, 32'h3C3C_3C3C, 4'b1000};
        vecs[2] = '{2'b00, 18'h0101, 32'h0000_0011, 18'h0100, 32'h1111_1111, 4'b0100};
        vecs[3] = '{2'b00, 18'h0103, 32'hFFFF_FF5A, 18'h0100, 32'h5A5A_5A5A, 4'b0001};
        vecs[4] = '{2'b01, 18'h0200, 32'h0000_1234, 18'h0200, 32'h1234_1234, 4'b1100};
        vecs[5] = '{2'b01, 18'h0301, 32'hFFFF_ABCD, 18'h0300, 32'hABCD_ABCD, 4'b0011};
        vecs[6] = '{2'b01, 18'h0302, 32'h5555_0F0F, 18'h0300, 32'h0F0F_0F0F, 4'b0011};
        vecs[7] = '{2'b10, 18'h0204, 32'hDEAD_BEEF, 18'h0204, 32'hDEAD_BEEF, 4'b1111};
        vecs[8] = '{2'b10, 18'h3FFFF, 32'h0123_4567, 18'h3FFFC, 32'h0123_4567, 4'b1111};

        reset = 1'b1;
        enable = 1'b1;
        st_valid = 1'b0;
        st_size = 2'b00;
        st_addr = '0;
        st_data = '0;
        dmem_if.dmem_wr_ack = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_req",   {31'd0, dmem_if.dmem_wr_req}, 32'd0);
        chk("rst_addr",  {14'd0, dmem_if.dmem_wr_addr}, 32'd0);
        chk("rst_data",  dmem_if.dmem_wr_data, 32'd0);
        chk("rst_be",    {28'd0, dmem_if.dmem_wr_be}, 32'd0);
        chk("rst_empty", {31'd0, sb_empty}, 32'd1);
        chk("rst_stall", {31'd0, st_stall}, 32'd0);
        reset = 1'b0;
        tick();

        // Single stores, ack tied high: accept, req one cycle later, one write
        dmem_if.dmem_wr_ack = 1'b1;
        for (int i = 0; i < 9; i++) begin
            offer(vecs[i].size, vecs[i].addr, vecs[i].data);
            chk($sformatf("v%0d_stall", i), {31'd0, st_stall}, 32'd0);
            tick();
            st_valid = 1'b0;
            chk($sformatf("v%0d_req_early", i), {31'd0, dmem_if.dmem_wr_req}, 32'd0);
            chk($sformatf("v%0d_notempty", i), {31'd0, sb_empty}, 32'd0);
            tick();
            chk($sformatf("v%0d_req", i), {31'd0, dmem_if.dmem_wr_req}, 32'd1);
            chk($sformatf("v%0d_addr", i), {14'd0, dmem_if.dmem_wr_addr}, {14'd0, vecs[i].exp_addr});
            chk($sformatf("v%0d_data", i), dmem_if.dmem_wr_data, vecs[i].exp_data);
            chk($sformatf("v%0d_be", i), {28'd0, dmem_if.dmem_wr_be}, {28'd0, vecs[i].exp_be});
            tick();
            chk($sformatf("v%0d_req_done", i), {31'd0, dmem_if.dmem_wr_req}, 32'd0);
            chk($sformatf("v%0d_empty", i), {31'd0, sb_empty}, 32'd1);
        end

        // Back-to-back drain of half then word
        offer(2'b01, 18'h0200, 32'h0000_1234);
        tick();
        offer(2'b10, 18'h0204, 32'hDEAD_BEEF);
        chk("b2b_req0", {31'd0, dmem_if.dmem_wr_req}, 32'd0);
        tick();
        st_valid = 1'b0;
        chk("b2b_req1", {31'd0, dmem_if.dmem_wr_req}, 32'd1);
        chk("b2b_addr1", {14'd0, dmem_if.dmem_wr_addr}, 32'h0000_0200);
        chk("b2b_data1", dmem_if.dmem_wr_data, 32'h1234_1234);
        chk("b2b_be1", {28'd0, dmem_if.dmem_wr_be}, 32'hC);
        tick();
        chk("b2b_req2", {31'd0, dmem_if.dmem_wr_req}, 32'd1);
        chk("b2b_addr2", {14'd0, dmem_if.dmem_wr_addr}, 32'h0000_0204);
        chk("b2b_data2", dmem_if.dmem_wr_data, 32'hDEAD_BEEF);
        chk("b2b_be2", {28'd0, dmem_if.dmem_wr_be}, 32'hF);
        tick();
        chk("b2b_req3", {31'd0, dmem_if.dmem_wr_req}, 32'd0);

        // Full buffer: third store stalls until the first ack, no push-through
        dmem_if.dmem_wr_ack = 1'b0;
        offer(2'b10, 18'h1000, 32'hAAAA_0001);
        tick();
        offer(2'b10, 18'h1004, 32'hAAAA_0002);
        chk("full_stallB", {31'd0, st_stall}, 32'd0);
        tick();
        offer(2'b10, 18'h1008, 32'hAAAA_0003);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("full_stallC%0d", i), {31'd0, st_stall}, 32'd1);
            chk($sformatf("full_addrA%0d", i), {14'd0, dmem_if.dmem_wr_addr}, 32'h0000_1000);
            tick();
        end
        dmem_if.dmem_wr_ack = 1'b1;
        chk("full_stall_at_ack", {31'd0, st_stall}, 32'd1);
        tick();
        dmem_if.dmem_wr_ack = 1'b0;
        chk("full_stall_freed", {31'd0, st_stall}, 32'd0);
        chk("full_addrB", {14'd0, dmem_if.dmem_wr_addr}, 32'h0000_1004);
        chk("full_dataB", dmem_if.dmem_wr_data, 32'hAAAA_0002);
        tick();
        st_valid = 1'b0;
        dmem_if.dmem_wr_ack = 1'b1;
        chk("full_holdB", {14'd0, dmem_if.dmem_wr_addr}, 32'h0000_1004);
        tick();
        chk("full_reqC", {31'd0, dmem_if.dmem_wr_req}, 32'd1);
        chk("full_addrC", {14'd0, dmem_if.dmem_wr_addr}, 32'h0000_1008);
        chk("full_dataC", dmem_if.dmem_wr_data, 32'hAAAA_0003);
        tick();
        chk("full_req_done", {31'd0, dmem_if.dmem_wr_req}, 32'd0);
        chk("full_empty", {31'd0, sb_empty}, 32'd1);

        // Asynchronous reset while a write is pending
        dmem_if.dmem_wr_ack = 1'b0;
        offer(2'b00, 18'h2001, 32'h0000_0077);
        tick();
        st_valid = 1'b0;
        tick();
        chk("rmid_req_before", {31'd0, dmem_if.dmem_wr_req}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rmid_req", {31'd0, dmem_if.dmem_wr_req}, 32'd0);
        chk("rmid_be", {28'd0, dmem_if.dmem_wr_be}, 32'd0);
        chk("rmid_empty", {31'd0, sb_empty}, 32'd1);
        #2;
        reset = 1'b0;
        dmem_if.dmem_wr_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rmid_noreq%0d", i), {31'd0, dmem_if.dmem_wr_req}, 32'd0);
        end

        // Illegal size is dropped without stalling
        offer(2'b11, 18'h0400, 32'h1111_2222);
        chk("ill_stall", {31'd0, st_stall}, 32'd0);
        tick();
        st_valid = 1'b0;
        chk("ill_empty", {31'd0, sb_empty}, 32'd1);
        tick();
        chk("ill_noreq", {31'd0, dmem_if.dmem_wr_req}, 32'd0);

        // enable low blocks the push
        enable = 1'b0;
        offer(2'b10, 18'h0500, 32'h3333_4444);
        tick();
        tick();
        st_valid = 1'b0;
        enable = 1'b1;
        chk("en_noreq", {31'd0, dmem_if.dmem_wr_req}, 32'd0);
        chk("en_empty", {31'd0, sb_empty}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
